aibcr3_txdig_seq: RTL and testbench

//  Transmit-side digital for one AIB data pad: decodes a 3-bit TX mode, sequences mode changes through a

---
 rtl/aibcr3_tx_pkg.sv | 39 +++
 rtl/aibcr3_txdig_seq_if.sv | 24 ++
 rtl/aibcr3_txdig_prbs7.sv | 39 +++
 rtl/aibcr3_txdig_seq.sv | 184 ++++++++++++++++++
 tb/tb_aibcr3_txdig_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/aibcr3_tx_pkg.sv
// Shared types and constants for the AIB TX digital sequencer: mode/state encodings, PRBS7 constants.
package aibcr3_tx_pkg;

  typedef enum logic [2:0] {
    ModeDis    = 3'b000,
    ModeAsync  = 3'b001,
    ModeDdr    = 3'b010,
    ModeClkfwd = 3'b011,
    ModeSdr    = 3'b100
  } tx_mode_e;

  typedef enum logic [1:0] {
    StDis,
    StQuiesce,
    StActive
  } tx_state_e;

  localparam logic [6:0] Prbs7Seed = 7'h7F;
  // x^7 + x^6 + 1: feedback is the parity of state bits 6 and 5
  localparam logic [6:0] Prbs7Taps = 7'b110_0000;

  // Unused encodings fall back to disabled so a bad strap never drives the pad.
  function automatic tx_mode_e decode_mode(input logic [2:0] raw);
    tx_mode_e mode;
    case (raw)
      3'b001:  mode = ModeAsync;
      3'b010:  mode = ModeDdr;
      3'b011:  mode = ModeClkfwd;
      3'b100:  mode = ModeSdr;
      default: mode = ModeDis;
    endcase
    return mode;
  endfunction

  function automatic logic [6:0] prbs7_step(input logic [6:0] state);
    return {state[5:0], ^(state & Prbs7Taps)};
  endfunction

endpackage

// File: rtl/aibcr3_txdig_seq_if.sv
// Core-side control/data bundle and pad-side outputs of the AIB TX sequencer.
interface aibcr3_txdig_seq_if;

  logic [2:0] itxen;
  logic       idat0;
  logic       idat1;
  logic       idat_async;
  logic       itx_prbs_en;
  logic       tx_dat;
  logic       tx_oe;
  logic       tx_active;
  logic [2:0] tx_mode;

  modport master (
    output itxen, idat0, idat1, idat_async, itx_prbs_en,
    input  tx_dat, tx_oe, tx_active, tx_mode
  );

  modport slave (
    input  itxen, idat0, idat1, idat_async, itx_prbs_en,
    output tx_dat, tx_oe, tx_active, tx_mode
  );

endinterface

// File: rtl/aibcr3_txdig_prbs7.sv
// Two-bit-per-cycle PRBS7 source; only built when AIBCR3_TX_PRBS_EN is defined.
`ifdef AIBCR3_TX_PRBS_EN
module aibcr3_txdig_prbs7
  import aibcr3_tx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic bit0_o,
  output logic bit1_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_cur;
  logic [6:0] lfsr_mid;
  logic [6:0] lfsr_nxt;
  logic       en_q;

  // A rising enable restarts the sequence from the seed in the same cycle.
  assign lfsr_cur = (en_i && !en_q) ? Prbs7Seed : lfsr_q;
  assign lfsr_mid = prbs7_step(lfsr_cur);
  assign lfsr_nxt = prbs7_step(lfsr_mid);
  assign bit0_o   = lfsr_mid[0];
  assign bit1_o   = lfsr_nxt[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Prbs7Seed;
      en_q   <= 1'b0;
    end else begin
      en_q <= en_i;
      if (en_i) begin
        lfsr_q <= lfsr_nxt;
      end
    end
  end

endmodule
`endif

// File: rtl/aibcr3_txdig_seq.sv
// AIB TX pad sequencer: mode decode, quiesce-before-activate FSM, DDR/SDR/CLKFWD/ASYNC launch.
// Optional PRBS7 data source under `define AIBCR3_TX_PRBS_EN.
module aibcr3_txdig_seq
  import aibcr3_tx_pkg::*;
#(
  parameter int unsigned QUIESCE_CYC = 4
) (
  input logic               iclkin_dist,
  input logic               irstb,
  input logic               ipadrstb,
  aibcr3_txdig_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(QUIESCE_CYC + 1);
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(QUIESCE_CYC);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  tx_state_e        state_q, state_d;
  tx_mode_e         tx_mode_q, tx_mode_d;
  tx_mode_e         pend_q, pend_d;
  tx_mode_e         mode_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic src0, src1;
  logic d0_d, d1_d;
  logic d0_q, d1_q;
  logic l0_q, l1_hold_q, l1_q;
  logic tx_dat, tx_oe, tx_active;

  assign mode_dec = ipadrstb ? decode_mode(bus.itxen) : ModeDis;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      state_q   <= StDis;
      tx_mode_q <= ModeDis;
      pend_q    <= ModeDis;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_mode_q <= tx_mode_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_mode_d = tx_mode_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StDis: begin
        if (mode_dec != ModeDis) begin
          state_d = StQuiesce;
          cnt_d   = CntLoad;
          pend_d  = mode_dec;
        end
      end
      StQuiesce: begin
        if (mode_dec == ModeDis) begin
          state_d   = StDis;
          tx_mode_d = ModeDis;
          cnt_d     = '0;
        end else if (mode_dec != pend_q) begin
          // Mode moved while quiescing: the full window restarts for the new mode.
          cnt_d  = CntLoad;
          pend_d = mode_dec;
        end else if (cnt_q == CntOne) begin
          state_d   = StActive;
          tx_mode_d = pend_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StActive: begin
        if (mode_dec == ModeDis) begin
          state_d   = StDis;
          tx_mode_d = ModeDis;
        end else if (mode_dec != tx_mode_q) begin
          state_d = StQuiesce;
          cnt_d   = CntLoad;
          pend_d  = mode_dec;
        end
      end
      default: begin
        state_d   = StDis;
        tx_mode_d = ModeDis;
      end
    endcase
  end

  always_comb begin
    tx_oe     = (state_q != StDis);
    tx_active = (state_q == StActive);
    tx_dat    = 1'b0;
    if (state_q == StActive) begin
      if (tx_mode_q == ModeAsync) begin
        tx_dat = bus.idat_async;
      end else begin
        tx_dat = iclkin_dist ? l0_q : l1_q;
      end
    end
  end

  assign bus.tx_dat    = tx_dat;
  assign bus.tx_oe     = tx_oe;
  assign bus.tx_active = tx_active;
  assign bus.tx_mode   = tx_mode_q;

  // ---------------------------------------------------------------- data source
`ifdef AIBCR3_TX_PRBS_EN
  logic prbs0, prbs1, prbs_sel;

  aibcr3_txdig_prbs7 u_prbs7 (
    .clk_i  (iclkin_dist),
    .rst_ni (irstb),
    .en_i   (bus.itx_prbs_en),
    .bit0_o (prbs0),
    .bit1_o (prbs1)
  );

  assign prbs_sel = bus.itx_prbs_en && ((tx_mode_d == ModeDdr) || (tx_mode_d == ModeSdr));
  assign src0     = prbs_sel ? prbs0 : bus.idat0;
  assign src1     = prbs_sel ? prbs1 : bus.idat1;
`else
  logic unused_prbs_en;
  assign unused_prbs_en = bus.itx_prbs_en;
  assign src0           = bus.idat0;
  assign src1           = bus.idat1;
`endif

  // ---------------------------------------------------------------- data path
  // Capture only when the next state is ACTIVE, so stale data never reaches the pad.
  always_comb begin
    d0_d = 1'b0;
    d1_d = 1'b0;
    if (state_d == StActive) begin
      case (tx_mode_d)
        ModeDdr: begin
          d0_d = src0;
          d1_d = src1;
        end
        ModeSdr: begin
          d0_d = src0;
          d1_d = src0;
        end
        ModeClkfwd: begin
          d0_d = 1'b1;
          d1_d = 1'b0;
        end
        default: begin
          d0_d = 1'b0;
          d1_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      d0_q      <= 1'b0;
      d1_q      <= 1'b0;
      l0_q      <= 1'b0;
      l1_hold_q <= 1'b0;
    end else begin
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      l0_q      <= d0_q;
      l1_hold_q <= d1_q;
    end
  end

  // d1 must survive past the next posedge to reach the low phase of the following cycle.
  always_ff @(negedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      l1_q <= 1'b0;
    end else begin
      l1_q <= l1_hold_q;
    end
  end

endmodule

// File: tb/tb_aibcr3_txdig_seq.sv
// Directed self-checking bench for aibcr3_txdig_seq (QUIESCE_CYC = 4).
module tb_aibcr3_txdig_seq;

  localparam int unsigned QCYC = 4;

  logic iclkin_dist;
  logic irstb;
  logic ipadrstb;
  int   n_checks;
  int   n_fail;

  aibcr3_txdig_seq_if bus ();

  aibcr3_txdig_seq #(
    .QUIESCE_CYC (QCYC)
  ) dut (
    .iclkin_dist (iclkin_dist),
    .irstb       (irstb),
    .ipadrstb    (ipadrstb),
    .bus         (bus)
  );

  initial iclkin_dist = 1'b0;
  always #5 iclkin_dist = ~iclkin_dist;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iclkin_dist);
    #2;
  endtask

  task automatic half();
    @(negedge iclkin_dist);
    #2;
  endtask

  task automatic go_active(input logic [2:0] mode);
    bus.itxen = mode;
    repeat (QCYC + 1) tick();
    check_eq("go_active", {31'd0, bus.tx_active}, 32'd1);
    check_eq("go_mode", {29'd0, bus.tx_mode}, {29'd0, mode});
  endtask

`ifdef AIBCR3_TX_PRBS_EN
  function automatic logic [6:0] ref_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ref_s;
    logic       e0, e1;
    n_checks = 0;
    n_fail   = 0;
    irstb           = 1'b0;
    ipadrstb        = 1'b1;
    bus.itxen       = 3'b000;
    bus.idat0       = 1'b0;
    bus.idat1       = 1'b0;
    bus.idat_async  = 1'b0;
    bus.itx_prbs_en = 1'b0;
    #12;
    check_eq("rst_oe", {31'd0, bus.tx_oe}, 32'd0);
    check_eq("rst_active", {31'd0, bus.tx_active}, 32'd0);
    check_eq("rst_mode", {29'd0, bus.tx_mode}, 32'd0);
    check_eq("rst_dat", {31'd0, bus.tx_dat}, 32'd0);

    // 1: DDR activation after 4 quiesce cycles
    irstb     = 1'b1;
    bus.itxen = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("q_oe", {31'd0, bus.tx_oe}, 32'd1);
      check_eq("q_active", {31'd0, bus.tx_active}, 32'd0);
      check_eq("q_dat_hi", {31'd0, bus.tx_dat}, 32'd0);
      half();
      check_eq("q_dat_lo", {31'd0, bus.tx_dat}, 32'd0);
    end

    // 2: DDR data, one cycle latency, dat0 high phase / dat1 low phase
    bus.idat0 = 1'b1;
    bus.idat1 = 1'b0;
    tick();
    check_eq("act_active", {31'd0, bus.tx_active}, 32'd1);
    check_eq("act_mode", {29'd0, bus.tx_mode}, 32'd2);
    check_eq("act_first_dat", {31'd0, bus.tx_dat}, 32'd0);
    bus.idat0 = 1'b0;
    bus.idat1 = 1'b1;
    tick();
    check_eq("ddr_a_hi", {31'd0, bus.tx_dat}, 32'd1);
    bus.idat0 = 1'b1;
    bus.idat1 = 1'b1;
    half();
    check_eq("ddr_a_lo", {31'd0, bus.tx_dat}, 32'd0);
    tick();
    check_eq("ddr_b_hi", {31'd0, bus.tx_dat}, 32'd0);
    half();
    check_eq("ddr_b_lo", {31'd0, bus.tx_dat}, 32'd1);
    tick();
    check_eq("ddr_c_hi", {31'd0, bus.tx_dat}, 32'd1);
    half();
    check_eq("ddr_c_lo", {31'd0, bus.tx_dat}, 32'd1);

    // 3: disable is immediate; mode change mid-quiesce restarts the window
    bus.itxen = 3'b000;
    tick();
    check_eq("dis_oe", {31'd0, bus.tx_oe}, 32'd0);
    check_eq("dis_dat", {31'd0, bus.tx_dat}, 32'd0);
    check_eq("dis_mode", {29'd0, bus.tx_mode}, 32'd0);
    bus.idat0 = 1'b0;
    bus.idat1 = 1'b1;
    bus.itxen = 3'b010;
    repeat (3) tick();
    bus.itxen = 3'b011;
    tick();
    check_eq("rs_active0", {31'd0, bus.tx_active}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rs_active", {31'd0, bus.tx_active}, 32'd0);
      check_eq("rs_oe", {31'd0, bus.tx_oe}, 32'd1);
    end
    tick();
    check_eq("cf_active", {31'd0, bus.tx_active}, 32'd1);
    check_eq("cf_mode", {29'd0, bus.tx_mode}, 32'd3);
    check_eq("cf_first_dat", {31'd0, bus.tx_dat}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("cf_hi", {31'd0, bus.tx_dat}, 32'd1);
      half();
      check_eq("cf_lo", {31'd0, bus.tx_dat}, 32'd0);
    end

    // 4: SDR holds dat0 for the whole cycle, then pad reset and async reset
    bus.idat0 = 1'b1;
    bus.idat1 = 1'b0;
    go_active(3'b100);
    tick();
    check_eq("sdr_a_hi", {31'd0, bus.tx_dat}, 32'd1);
    half();
    check_eq("sdr_a_lo", {31'd0, bus.tx_dat}, 32'd1);
    bus.idat0 = 1'b0;
    bus.idat1 = 1'b1;
    tick();
    tick();
    check_eq("sdr_b_hi", {31'd0, bus.tx_dat}, 32'd0);
    half();
    check_eq("sdr_b_lo", {31'd0, bus.tx_dat}, 32'd0);
    ipadrstb = 1'b0;
    #1;
    check_eq("padrst_pre_oe", {31'd0, bus.tx_oe}, 32'd1);
    tick();
    check_eq("padrst_oe", {31'd0, bus.tx_oe}, 32'd0);
    check_eq("padrst_active", {31'd0, bus.tx_active}, 32'd0);
    check_eq("padrst_mode", {29'd0, bus.tx_mode}, 32'd0);
    check_eq("padrst_dat", {31'd0, bus.tx_dat}, 32'd0);
    ipadrstb  = 1'b1;
    bus.itxen = 3'b000;
    tick();
    bus.idat0 = 1'b1;
    bus.idat1 = 1'b1;
    go_active(3'b010);
    tick();
    check_eq("pre_rst_dat", {31'd0, bus.tx_dat}, 32'd1);
    irstb = 1'b0;
    #1;
    check_eq("arst_oe", {31'd0, bus.tx_oe}, 32'd0);
    check_eq("arst_active", {31'd0, bus.tx_active}, 32'd0);
    check_eq("arst_dat", {31'd0, bus.tx_dat}, 32'd0);
    check_eq("arst_mode", {29'd0, bus.tx_mode}, 32'd0);
    bus.itxen = 3'b000;
    #1;
    irstb = 1'b1;
    tick();

    // 5: ASYNC passthrough, then an illegal mode decodes as disabled
    go_active(3'b001);
    bus.idat_async = 1'b1;
    #1;
    check_eq("async_1", {31'd0, bus.tx_dat}, 32'd1);
    bus.idat_async = 1'b0;
    #1;
    check_eq("async_0", {31'd0, bus.tx_dat}, 32'd0);
    half();
    bus.idat_async = 1'b1;
    #1;
    check_eq("async_lo_1", {31'd0, bus.tx_dat}, 32'd1);
    bus.itxen = 3'b111;
    tick();
    check_eq("bad_oe", {31'd0, bus.tx_oe}, 32'd0);
    check_eq("bad_mode", {29'd0, bus.tx_mode}, 32'd0);
    check_eq("bad_dat", {31'd0, bus.tx_dat}, 32'd0);
    tick();
    check_eq("bad_oe_hold", {31'd0, bus.tx_oe}, 32'd0);

    // 6: DDR with the PRBS request asserted at activation
    bus.idat0 = 1'b1;
    bus.idat1 = 1'b0;
    bus.itxen = 3'b010;
    repeat (QCYC) tick();
    bus.itx_prbs_en = 1'b1;
    tick();
    check_eq("prbs_active", {31'd0, bus.tx_active}, 32'd1);
    ref_s = 7'h7F;
    for (int i = 0; i < 7; i++) begin
`ifdef AIBCR3_TX_PRBS_EN
      ref_s = ref_step(ref_s);
      e0    = ref_s[0];
      ref_s = ref_step(ref_s);
      e1    = ref_s[0];
`else
      e0 = 1'b1;
      e1 = 1'b0;
`endif
      tick();
      check_eq("prbs_hi", {31'd0, bus.tx_dat}, {31'd0, e0});
      half();
      check_eq("prbs_lo", {31'd0, bus.tx_dat}, {31'd0, e1});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
